// File: rtl/apb_slave_mem.sv
// APB completer backed by a register-file memory with a fixed number of wait states.
// Define APB_SLAVE_ERR_EN to flag out-of-range addresses with pslverr; otherwise addresses wrap modulo DEPTH.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int           IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_I = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0]   WAIT_N  = 4'(WAIT_CYCLES);

  logic [1:0]            state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic                  enter_resp;
  logic                  complete;
  logic                  addr_err;
  logic                  hit;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign idx = paddr[IDX_W-1:0];
  // Guards the array bound when DEPTH is not a power of two.
  assign hit = ({1'b0, idx} < DEPTH_I);

`ifdef APB_SLAVE_ERR_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
  assign addr_err = ({1'b0, paddr} >= DEPTH_A);
`else
  logic unused_addr;
  assign unused_addr = ^paddr;
  assign addr_err    = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    enter_resp = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          cnt_d = WAIT_N;
          if (WAIT_N == 4'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable) begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      RESP: begin
        state_d  = IDLE;
        complete = psel && penable;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      cnt     <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (enter_resp) begin
        pready  <= 1'b1;
        pslverr <= addr_err;
        if (!pwrite) begin
          prdata <= (addr_err || !hit) ? '0 : mem[idx];
        end
      end else if (state == RESP) begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
      end
      // Writes commit on the completion edge, so a following setup already sees the data.
      if (complete && pwrite && !addr_err && hit) begin
        mem[idx] <= pwdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (0, 2 and 3 wait states) driven from a vector table and hand-written sequences.
// Expectations adapt to whether APB_SLAVE_ERR_EN is defined.
module tb_apb_slave_mem;

`ifdef APB_SLAVE_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic       pclk;
  logic       presetn;
  logic       psel    [3];
  logic       penable [3];
  logic       pwrite  [3];
  logic [7:0] paddr   [3];
  logic [7:0] pwdata  [3];
  logic [7:0] prdata  [3];
  logic       pready  [3];
  logic       pslverr [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_mem #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8),
      .DEPTH      (64),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) dut (
      .pclk   (pclk),
      .presetn(presetn),
      .psel   (psel[g]),
      .penable(penable[g]),
      .pwrite (pwrite[g]),
      .paddr  (paddr[g]),
      .pwdata (pwdata[g]),
      .prdata (prdata[g]),
      .pready (pready[g]),
      .pslverr(pslverr[g])
    );
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int unsigned d;
    bit          wr;
    logic [7:0]  a;
    logic [7:0]  wd;
    logic [7:0]  erd;
    bit          eerr;
  } vec_t;

  typedef struct {
    logic [7:0]  rd;
    bit          err;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic int unsigned waits(input int unsigned d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic check(input string name, input int unsigned d,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the completion edge so the next call is back-to-back.
  task automatic xfer(input int unsigned d, input bit wr, input logic [7:0] a,
                      input logic [7:0] wd, input logic [7:0] erd, input bit eerr);
    exp_t        e;
    int unsigned acc;
    e.rd  = erd;
    e.err = eerr;
    e.acc = waits(d) + 1;
    sb.push_back(e);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = a;
    pwdata[d]  = wd;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    acc = 1;
    while (!pready[d] && acc < 20) begin
      @(posedge pclk); #1;
      acc++;
    end
    e = sb.pop_front();
    if (!pready[d]) begin
      check("pready_timeout", d, 32'(pready[d]), 32'd1);
    end else begin
      check("access_cycles", d, 32'(acc), 32'(e.acc));
      check("prdata", d, 32'(prdata[d]), 32'(e.rd));
      check("pslverr", d, 32'(pslverr[d]), 32'(e.err));
    end
    @(posedge pclk); #1;
    check("pready_pulse", d, 32'(pready[d]), 32'd0);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  vec_t vecs[16];
  bit   seen;

  initial begin
    vecs[0]  = '{0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    vecs[2]  = '{0, 1'b1, 8'h05, 8'h01, 8'hA5, 1'b0};
    vecs[3]  = '{0, 1'b1, 8'h06, 8'h02, 8'hA5, 1'b0};
    vecs[4]  = '{0, 1'b0, 8'h05, 8'h00, 8'h01, 1'b0};
    vecs[5]  = '{0, 1'b0, 8'h06, 8'h00, 8'h02, 1'b0};
    vecs[6]  = '{0, 1'b1, 8'h3F, 8'hC3, 8'h02, 1'b0};
    vecs[7]  = '{0, 1'b0, 8'h3F, 8'h00, 8'hC3, 1'b0};
    vecs[8]  = '{0, 1'b1, 8'h40, 8'h77, 8'hC3, ERR};
    vecs[9]  = '{0, 1'b0, 8'h00, 8'h00, (ERR ? 8'h00 : 8'h77), 1'b0};
    vecs[10] = '{0, 1'b0, 8'h40, 8'h00, (ERR ? 8'h00 : 8'h77), ERR};
    vecs[11] = '{0, 1'b0, 8'hFF, 8'h00, (ERR ? 8'h00 : 8'hC3), ERR};
    vecs[12] = '{1, 1'b1, 8'h10, 8'h3C, 8'h00, 1'b0};
    vecs[13] = '{1, 1'b0, 8'h10, 8'h00, 8'h3C, 1'b0};
    vecs[14] = '{1, 1'b1, 8'h01, 8'h55, 8'h3C, 1'b0};
    vecs[15] = '{1, 1'b0, 8'h01, 8'h00, 8'h55, 1'b0};

    presetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = '0;  pwdata[i] = '0;
    end
    @(posedge pclk); @(posedge pclk); #1;
    for (int unsigned i = 0; i < 3; i++) begin
      check("reset_prdata", i, 32'(prdata[i]), 32'd0);
      check("reset_pready", i, 32'(pready[i]), 32'd0);
      check("reset_pslverr", i, 32'(pslverr[i]), 32'd0);
    end
    presetn = 1'b1;
    @(posedge pclk); #1;

    for (int i = 0; i < 16; i++) begin
      xfer(vecs[i].d, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].erd, vecs[i].eerr);
    end

    // Abort: 3 wait states, psel dropped during the second access cycle.
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h08; pwdata[2] = 8'hFF;
    @(posedge pclk); #1;
    penable[2] = 1'b1;
    seen = pready[2];
    @(posedge pclk); #1;
    seen = seen | pready[2];
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      seen = seen | pready[2];
    end
    check("abort_no_pready", 2, 32'(seen), 32'd0);
    xfer(2, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0);

    // Reset in the middle of a write's wait period on the 2-wait instance.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h01; pwdata[1] = 8'hAA;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    check("async_rst_prdata", 1, 32'(prdata[1]), 32'd0);
    check("async_rst_pready", 1, 32'(pready[1]), 32'd0);
    check("async_rst_prdata", 0, 32'(prdata[0]), 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge pclk); @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer that terminates one slave select of the two-slave APB subsystem. It accepts setup/access transfers from the APB bridge, services them from an internal register-file memory with a fixed number of wait states, and returns read data, PREADY and PSLVERR. It is the responder counterpart of the bridge that is driven through the transfer/READ_WRITE/address/data test interface.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of paddr (slave-local, select bit already stripped by bridge)
- DATA_WIDTH, 8, width of pwdata/prdata
- DEPTH, 64, number of memory words; valid addresses 0..DEPTH-1; DEPTH <= 2**ADDR_WIDTH
- WAIT_CYCLES, 0, wait states inserted per transfer, legal range 0..15

Ports:
- pclk  in  1  APB clock, all logic on rising edge
- presetn  in  1  asynchronous active-low reset
- psel  in  1  slave select
- penable  in  1  access-phase qualifier
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  word address
- pwdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data, registered
- pready  out  1  transfer completion, registered
- pslverr  out  1  error response, registered, meaningful only with pready=1

## Operation
- Memory: DEPTH x DATA_WIDTH flops, all cleared to 0 on reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on psel=1 & penable=0 (setup) load cnt <= WAIT_CYCLES; if WAIT_CYCLES==0 go RESP, else WAIT. penable=1 without prior setup ignored.
- WAIT: each cycle with psel=1 & penable=1 decrement cnt; when cnt==1 go RESP. psel=0 -> abort to IDLE, no side effects.
- Entering RESP: pready <= 1; pslverr <= address error; for reads prdata <= mem[paddr] (0 on error).
- RESP (pready=1, psel & penable sampled): write commits mem[paddr] <= pwdata unless error; pready <= 0, pslverr <= 0; next state IDLE. If psel=1 & penable=0 in the same cycle as completion is impossible by protocol; next setup is sampled in IDLE the following cycle.
- prdata holds its last value between reads; writes never change prdata.
- Address error: paddr >= DEPTH (see Configuration).

## Timing
- Reset values: prdata=0, pready=0, pslverr=0, state IDLE, cnt=0, memory 0.
- Setup sampled at edge E0. WAIT_CYCLES=N: pready high during access cycle N+1 (after edge E0+N), transfer completes at edge E0+N+1. Total transfer = N+2 cycles.
- pready high for exactly one cycle per transfer; pslverr only ever high coincident with pready.
- Write data visible to a read whose setup is sampled at or after the completion edge.
- Back-to-back: setup in the cycle after completion is accepted with no idle gap.
- Reset mid-transfer: all state returns to reset values immediately (asynchronous); the in-flight write is lost.
- Inputs other than psel are don't-care in IDLE except during setup; paddr/pwrite/pwdata assumed stable from setup through completion.

## Configuration
- APB_SLAVE_ERR_EN defined: out-of-range addresses (paddr >= DEPTH) complete with pslverr=1, writes discarded, reads return 0.
- Not defined: pslverr tied 0; address taken modulo DEPTH (low log2(DEPTH) bits), every access hits memory.

## Test plan
- WAIT_CYCLES=0: write 0xA5 to 0x10, then read 0x10 -> write completes in 2 cycles, read prdata=0xA5, pslverr=0.
- WAIT_CYCLES=2: read 0x10 after writing 0x3C -> pready low for 2 access cycles, high in 3rd, prdata=0x3C, transfer 4 cycles.
- APB_SLAVE_ERR_EN, DEPTH=64: write 0x77 to 0x40 -> pslverr=1 with pready; read 0x00 unchanged; read 0x40 -> prdata=0, pslverr=1. Without macro: write 0x40 lands at 0x00, read 0x00 = 0x77.
- Back-to-back writes 0x01->0x05, 0x02->0x06 then reads -> no idle cycles needed, reads return 0x01, 0x02.
- Abort: WAIT_CYCLES=3, write 0xFF to 0x08, drop psel in 2nd access cycle -> pready never asserts, mem[0x08] remains 0.
- Reset: assert presetn=0 mid-wait of a write after prior write 0x55 to 0x01 -> outputs 0 immediately, mem[0x01] reads 0 afterwards.
